// File: rtl/pulse_xy_meter.sv
// ============================================================================
// pulse_xy_meter
// ----------------------------------------------------------------------------
// Downstream measurement stage for the X/Y pulse-shaping output pair.
// Both pulse inputs are synchronised into the sysclk domain and edge
// detected. Every X cycle (X rise to next X rise) is measured for:
//   - its period in sysclk cycles,
//   - its X high width,
//   - the delay from the X rise to the first following Y rise.
// Each completed cycle is published on the registered result outputs together
// with a one-cycle meas_valid strobe. A cycle without any Y rise is reported
// as y_missing with an all-ones delay. If X stops toggling long enough for
// the period counter to reach its maximum, the sticky timeout flag is raised
// and the meter returns to IDLE.
//
// Ports:
//   sysclk      in   system clock, rising edge
//   reset       in   synchronous, active-high reset
//   Pulse_X     in   asynchronous X pulse
//   Pulse_Y     in   asynchronous Y pulse
//   meas_en     in   1 = measure, 0 = force IDLE and hold results
//   period_x    out  [CNT_W] cycles between the last two X rises
//   width_x     out  [CNT_W] X high cycles in the last completed X cycle
//   delay_xy    out  [CNT_W] X rise to first Y rise; all-ones if no Y rise
//   y_missing   out  last completed X cycle had no Y rise
//   meas_valid  out  one-cycle strobe, results updated this cycle
//   timeout     out  sticky, X stalled for 2^CNT_W-1 cycles
// ============================================================================
module pulse_xy_meter #(
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2    // legal range 2..3
) (
    input  logic             sysclk,
    input  logic             reset,
    input  logic             Pulse_X,
    input  logic             Pulse_Y,
    input  logic             meas_en,
    output logic [CNT_W-1:0] period_x,
    output logic [CNT_W-1:0] width_x,
    output logic [CNT_W-1:0] delay_xy,
    output logic             y_missing,
    output logic             meas_valid,
    output logic             timeout
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_ARMED = 1'b1;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // Saturating increment shared by all measurement counters.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_ONE;
    endfunction

    // ------------------------------------------------------------------
    // Synchronisers and edge detection
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] x_sync_q, x_sync_d;
    logic [SYNC_STAGES-1:0] y_sync_q, y_sync_d;
    logic                   xd_q, xd_d;
    logic                   yd_q, yd_d;

    logic xs, ys;
    logic rise_x, fall_x, rise_y;

    always_comb begin
        x_sync_d = {x_sync_q[SYNC_STAGES-2:0], Pulse_X};
        y_sync_d = {y_sync_q[SYNC_STAGES-2:0], Pulse_Y};
        xs       = x_sync_q[SYNC_STAGES-1];
        ys       = y_sync_q[SYNC_STAGES-1];
        xd_d     = xs;
        yd_d     = ys;
        rise_x   = xs & ~xd_q;
        fall_x   = ~xs & xd_q;
        rise_y   = ys & ~yd_q;
    end

    // ------------------------------------------------------------------
    // Measurement state
    // ------------------------------------------------------------------
    logic [0:0]       state_q,   state_d;
    logic [CNT_W-1:0] per_cnt_q, per_cnt_d;
    logic [CNT_W-1:0] wid_cnt_q, wid_cnt_d;
    logic [CNT_W-1:0] del_cnt_q, del_cnt_d;
    logic [CNT_W-1:0] del_cap_q, del_cap_d;
    logic             y_seen_q,  y_seen_d;
    logic             x_fell_q,  x_fell_d;

    logic [CNT_W-1:0] period_x_q,   period_x_d;
    logic [CNT_W-1:0] width_x_q,    width_x_d;
    logic [CNT_W-1:0] delay_xy_q,   delay_xy_d;
    logic             y_missing_q,  y_missing_d;
    logic             meas_valid_q, meas_valid_d;
    logic             timeout_q,    timeout_d;

    logic [CNT_W-1:0] per_inc;

    // NOTE: every signal assigned here gets a default first, so no path
    // through the block leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d      = state_q;
        per_cnt_d    = per_cnt_q;
        wid_cnt_d    = wid_cnt_q;
        del_cnt_d    = del_cnt_q;
        del_cap_d    = del_cap_q;
        y_seen_d     = y_seen_q;
        x_fell_d     = x_fell_q;
        period_x_d   = period_x_q;
        width_x_d    = width_x_q;
        delay_xy_d   = delay_xy_q;
        y_missing_d  = y_missing_q;
        timeout_d    = timeout_q;
        meas_valid_d = 1'b0;
        per_inc      = sat_inc(per_cnt_q);

        if (!meas_en) begin
            // Disabled: drop back to IDLE, results and timeout hold.
            state_d = ST_IDLE;
        end else if (rise_x) begin
            // A rise in ARMED closes the running cycle; in IDLE it only arms.
            if (state_q == ST_ARMED) begin
                period_x_d   = per_cnt_q;
                // X that never fell was high for the whole cycle.
                width_x_d    = x_fell_q ? wid_cnt_q : per_cnt_q;
                delay_xy_d   = y_seen_q ? del_cap_q : CNT_MAX;
                y_missing_d  = ~y_seen_q;
                timeout_d    = 1'b0;
                meas_valid_d = 1'b1;
            end
            state_d   = ST_ARMED;
            per_cnt_d = CNT_ONE;
            wid_cnt_d = CNT_ONE;
            del_cnt_d = CNT_ONE;
            x_fell_d  = 1'b0;
            // A Y rise coincident with the X rise belongs to the new cycle.
            y_seen_d  = rise_y;
            del_cap_d = '0;
        end else if (state_q == ST_ARMED) begin
            per_cnt_d = per_inc;
            del_cnt_d = sat_inc(del_cnt_q);
            if (xs && !x_fell_q) begin
                wid_cnt_d = sat_inc(wid_cnt_q);
            end
            if (fall_x) begin
                x_fell_d = 1'b1;
            end
            // Only the first Y rise of the X cycle is kept.
            if (rise_y && !y_seen_q) begin
                y_seen_d  = 1'b1;
                del_cap_d = del_cnt_q;
            end
            // Period counter about to hit its ceiling: X has stalled.
            if (per_inc == CNT_MAX) begin
                timeout_d = 1'b1;
                state_d   = ST_IDLE;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the values from before this edge regardless of order.
    always_ff @(posedge sysclk) begin
        if (reset) begin
            x_sync_q     <= '0;
            y_sync_q     <= '0;
            xd_q         <= 1'b0;
            yd_q         <= 1'b0;
            state_q      <= ST_IDLE;
            per_cnt_q    <= '0;
            wid_cnt_q    <= '0;
            del_cnt_q    <= '0;
            del_cap_q    <= '0;
            y_seen_q     <= 1'b0;
            x_fell_q     <= 1'b0;
            period_x_q   <= '0;
            width_x_q    <= '0;
            delay_xy_q   <= '0;
            y_missing_q  <= 1'b0;
            meas_valid_q <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            x_sync_q     <= x_sync_d;
            y_sync_q     <= y_sync_d;
            xd_q         <= xd_d;
            yd_q         <= yd_d;
            state_q      <= state_d;
            per_cnt_q    <= per_cnt_d;
            wid_cnt_q    <= wid_cnt_d;
            del_cnt_q    <= del_cnt_d;
            del_cap_q    <= del_cap_d;
            y_seen_q     <= y_seen_d;
            x_fell_q     <= x_fell_d;
            period_x_q   <= period_x_d;
            width_x_q    <= width_x_d;
            delay_xy_q   <= delay_xy_d;
            y_missing_q  <= y_missing_d;
            meas_valid_q <= meas_valid_d;
            timeout_q    <= timeout_d;
        end
    end

    assign period_x   = period_x_q;
    assign width_x    = width_x_q;
    assign delay_xy   = delay_xy_q;
    assign y_missing  = y_missing_q;
    assign meas_valid = meas_valid_q;
    assign timeout    = timeout_q;

endmodule
